// File: rtl/demux_ctrl_pkg.sv
// Shared definitions for the demux_ctrl credit scheduler: state encodings,
// default widths and the statistics counter helper.
package demux_ctrl_pkg;

  localparam int DATA_W_DEF   = 6;
  localparam int DEST_BIT_DEF = 4;
  localparam int CRED_W_DEF   = 3;
  localparam int CNT_W        = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/demux_ctrl_credit.sv
// Per-destination credit counter: reloads from the threshold while loading,
// otherwise tracks pushes (-1) and frees (+1) and flags a free past the threshold.
module demux_ctrl_credit
  import demux_ctrl_pkg::*;
#(
  parameter int CRED_W = CRED_W_DEF
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              load,
  input  logic              hold,
  input  logic [CRED_W-1:0] thr,
  input  logic              push,
  input  logic              free,
  output logic [CRED_W-1:0] cred,
  output logic              zero,
  output logic              full,
  output logic              ovf
);

  logic [CRED_W-1:0] thr_q, thr_d;
  logic [CRED_W-1:0] cred_q, cred_d;

  assign cred = cred_q;
  assign zero = (cred_q == '0);
  assign full = (cred_q == thr_q);
  // A simultaneous push cancels the free, so only an unmatched free can overflow.
  assign ovf  = free && !push && full;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    thr_d  = thr_q;
    cred_d = cred_q;
    if (load) begin
      thr_d  = thr;
      cred_d = thr;
    end else if (!hold) begin
      if (push && !free) begin
        cred_d = cred_q - CRED_W'(1);
      end else if (free && !push) begin
        cred_d = cred_q + CRED_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      thr_q  <= '0;
      cred_q <= '0;
    end else begin
      thr_q  <= thr_d;
      cred_q <= cred_d;
    end
  end

endmodule

// File: rtl/demux_ctrl.sv
// Credit-based scheduler draining a source FIFO into a 1:2 demux.
// Optional per-destination push counters are built when DEMUX_CTRL_STATS_EN is defined.
module demux_ctrl
  import demux_ctrl_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEST_BIT = DEST_BIT_DEF,
  parameter int CRED_W   = CRED_W_DEF
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              init,
  input  logic [CRED_W-1:0] umbral_0,
  input  logic [CRED_W-1:0] umbral_1,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_pop,
  input  logic              free_0,
  input  logic              free_1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              selector_out,
  output logic [2:0]        state,
  output logic              idle_out,
  output logic              error_out
`ifdef DEMUX_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0]  cnt_0,
  output logic [CNT_W-1:0]  cnt_1
`endif
);

  state_e state_q, state_d;

  logic              dest;
  logic              credit_live;
  logic              load;
  logic              hold;
  logic              base_pop;
  logic              pop;
  logic              ovf_any;
  logic [1:0]        push_req;
  logic [1:0]        free_live;
  logic [1:0]        zero_w;
  logic [1:0]        full_w;
  logic [1:0]        ovf_w;
  logic [CRED_W-1:0] cred_0_w;
  logic [CRED_W-1:0] cred_1_w;

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              sel_q, sel_d;

  assign dest        = fifo_data[DEST_BIT];
  assign credit_live = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
  assign free_live   = {free_1 && credit_live, free_0 && credit_live};

  // Head-of-line: only the head word is considered; a starved destination stalls everything.
  assign base_pop = (state_q == ST_ACTIVE) && !fifo_empty && !zero_w[dest];
  assign push_req = {base_pop && dest, base_pop && !dest};
  assign ovf_any  = |ovf_w;
  assign pop      = base_pop && !ovf_any;
  assign hold     = ovf_any || (state_q == ST_ERROR);
  assign load     = (state_q == ST_INIT);

  demux_ctrl_credit #(.CRED_W(CRED_W)) u_credit_0 (
    .clk     (clk),
    .reset_L (reset_L),
    .load    (load),
    .hold    (hold),
    .thr     (umbral_0),
    .push    (push_req[0]),
    .free    (free_live[0]),
    .cred    (cred_0_w),
    .zero    (zero_w[0]),
    .full    (full_w[0]),
    .ovf     (ovf_w[0])
  );

  demux_ctrl_credit #(.CRED_W(CRED_W)) u_credit_1 (
    .clk     (clk),
    .reset_L (reset_L),
    .load    (load),
    .hold    (hold),
    .thr     (umbral_1),
    .push    (push_req[1]),
    .free    (free_live[1]),
    .cred    (cred_1_w),
    .zero    (zero_w[1]),
    .full    (full_w[1]),
    .ovf     (ovf_w[1])
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (ovf_any)          state_d = ST_ERROR;
        else if (init)        state_d = ST_INIT;
        else if (!fifo_empty) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (ovf_any)         state_d = ST_ERROR;
        else if (init)       state_d = ST_INIT;
        else if (fifo_empty) state_d = ST_IDLE;
      end
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state_q <= ST_RESET;
    else          state_q <= state_d;
  end

  // Registered demux drive: a word popped this cycle is presented next cycle.
  always_comb begin
    data_d  = pop ? fifo_data : '0;
    valid_d = pop;
    sel_d   = pop && dest;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
    end
  end

  assign fifo_pop     = pop;
  assign data_out     = data_q;
  assign valid_out    = valid_q;
  assign selector_out = sel_q;
  assign state        = state_q;
  assign error_out    = (state_q == ST_ERROR);
  assign idle_out     = (state_q == ST_IDLE) && full_w[0] && full_w[1];

  a_pop_has_credit : assert property (@(posedge clk) disable iff (!reset_L)
    fifo_pop |-> ((dest ? cred_1_w : cred_0_w) != '0));

`ifdef DEMUX_CTRL_STATS_EN
  logic [CNT_W-1:0] cnt_0_q, cnt_0_d;
  logic [CNT_W-1:0] cnt_1_q, cnt_1_d;

  always_comb begin
    cnt_0_d = cnt_0_q;
    cnt_1_d = cnt_1_q;
    if ((state_q == ST_RESET) || (state_q == ST_INIT)) begin
      cnt_0_d = '0;
      cnt_1_d = '0;
    end else if (pop) begin
      if (dest) cnt_1_d = sat_inc(cnt_1_q);
      else      cnt_0_d = sat_inc(cnt_0_q);
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt_0_q <= '0;
      cnt_1_q <= '0;
    end else begin
      cnt_0_q <= cnt_0_d;
      cnt_1_q <= cnt_1_d;
    end
  end

  assign cnt_0 = cnt_0_q;
  assign cnt_1 = cnt_1_q;
`else
  // Statistics disabled: only the scheduling datapath is built.
`endif

endmodule

// File: tb/tb_demux_ctrl.sv
// Bench for demux_ctrl: directed vector table, hand-written error/reset sequences
// and a randomized run scored against a behavioural credit model.
module tb_demux_ctrl;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       init;
  logic [2:0] umbral_0, umbral_1;
  logic       fifo_empty;
  logic [5:0] fifo_data;
  logic       fifo_pop;
  logic       free_0, free_1;
  logic [5:0] data_out;
  logic       valid_out;
  logic       selector_out;
  logic [2:0] state;
  logic       idle_out;
  logic       error_out;
`ifdef DEMUX_CTRL_STATS_EN
  logic [7:0] cnt_0, cnt_1;
`endif

  demux_ctrl dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .init         (init),
    .umbral_0     (umbral_0),
    .umbral_1     (umbral_1),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_pop     (fifo_pop),
    .free_0       (free_0),
    .free_1       (free_1),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .selector_out (selector_out),
    .state        (state),
    .idle_out     (idle_out),
    .error_out    (error_out)
`ifdef DEMUX_CTRL_STATS_EN
    ,
    .cnt_0        (cnt_0),
    .cnt_1        (cnt_1)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       init;
    logic [2:0] u0, u1;
    logic       empty;
    logic [5:0] data;
    logic       f0, f1;
    logic       e_pop, e_valid;
    logic [5:0] e_data;
    logic       e_sel;
    logic [2:0] e_state;
    logic       e_idle, e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic in_init, input logic [2:0] u0, input logic [2:0] u1,
                              input logic empty, input logic [5:0] data,
                              input logic f0, input logic f1,
                              input logic e_pop, input logic e_valid, input logic [5:0] e_data,
                              input logic e_sel, input logic [2:0] e_state,
                              input logic e_idle, input logic e_err);
    vec_t v;
    v.init = in_init; v.u0 = u0; v.u1 = u1; v.empty = empty; v.data = data;
    v.f0 = f0; v.f1 = f1; v.e_pop = e_pop; v.e_valid = e_valid; v.e_data = e_data;
    v.e_sel = e_sel; v.e_state = e_state; v.e_idle = e_idle; v.e_err = e_err;
    return v;
  endfunction

  // Behavioural model: mode numbers are the documented state codes.
  int         m_mode;
  int         m_cred[2];
  int         m_thr[2];
  int         m_cnt[2];
  logic       m_valid;
  logic [5:0] m_data;
  logic       m_sel;
  logic [5:0] src_q[$];

  initial begin
    reset_L = 1'b0; init = 1'b0; umbral_0 = '0; umbral_1 = '0;
    fifo_empty = 1'b1; fifo_data = '0; free_0 = 1'b0; free_1 = 1'b0;

    //                init u0 u1 emp data   f0 f1  pop val edata  sel st idle err
    vecs.push_back(mk(1, 4, 2, 1, 6'h00, 0, 0,  0, 0, 6'h00, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4, 2, 1, 6'h00, 0, 0,  0, 0, 6'h00, 0, 1, 0, 0));
    vecs.push_back(mk(0, 4, 2, 1, 6'h00, 0, 0,  0, 0, 6'h00, 0, 1, 0, 0));
    vecs.push_back(mk(0, 4, 2, 1, 6'h00, 0, 0,  0, 0, 6'h00, 0, 2, 1, 0));
    vecs.push_back(mk(0, 4, 2, 0, 6'h05, 0, 0,  0, 0, 6'h00, 0, 2, 1, 0));
    vecs.push_back(mk(0, 4, 2, 0, 6'h05, 0, 0,  1, 0, 6'h00, 0, 3, 0, 0));
    vecs.push_back(mk(0, 4, 2, 0, 6'h15, 0, 0,  1, 1, 6'h05, 0, 3, 0, 0));
    vecs.push_back(mk(0, 4, 2, 0, 6'h07, 0, 0,  1, 1, 6'h15, 1, 3, 0, 0));
    vecs.push_back(mk(0, 4, 2, 1, 6'h00, 0, 0,  0, 1, 6'h07, 0, 3, 0, 0));
    vecs.push_back(mk(0, 4, 2, 1, 6'h00, 0, 0,  0, 0, 6'h00, 0, 2, 0, 0));
    vecs.push_back(mk(1, 4, 2, 1, 6'h00, 0, 0,  0, 0, 6'h00, 0, 2, 0, 0));
    vecs.push_back(mk(1, 4, 2, 1, 6'h00, 0, 0,  0, 0, 6'h00, 0, 1, 0, 0));
    vecs.push_back(mk(0, 4, 2, 1, 6'h00, 0, 0,  0, 0, 6'h00, 0, 1, 0, 0));
    vecs.push_back(mk(0, 4, 2, 0, 6'h10, 0, 0,  0, 0, 6'h00, 0, 2, 1, 0));
    vecs.push_back(mk(0, 4, 2, 0, 6'h10, 0, 0,  1, 0, 6'h00, 0, 3, 0, 0));
    vecs.push_back(mk(0, 4, 2, 0, 6'h11, 0, 0,  1, 1, 6'h10, 1, 3, 0, 0));
    vecs.push_back(mk(0, 4, 2, 0, 6'h12, 0, 0,  0, 1, 6'h11, 1, 3, 0, 0));
    vecs.push_back(mk(0, 4, 2, 0, 6'h12, 0, 1,  0, 0, 6'h00, 0, 3, 0, 0));
    vecs.push_back(mk(0, 4, 2, 0, 6'h12, 0, 0,  1, 0, 6'h00, 0, 3, 0, 0));
    vecs.push_back(mk(0, 4, 2, 0, 6'h13, 0, 0,  0, 1, 6'h12, 1, 3, 0, 0));
    vecs.push_back(mk(1, 4, 2, 1, 6'h00, 0, 0,  0, 0, 6'h00, 0, 3, 0, 0));
    vecs.push_back(mk(1, 1, 2, 1, 6'h00, 0, 0,  0, 0, 6'h00, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 2, 1, 6'h00, 0, 0,  0, 0, 6'h00, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 2, 0, 6'h01, 0, 0,  0, 0, 6'h00, 0, 2, 1, 0));
    vecs.push_back(mk(0, 1, 2, 0, 6'h01, 0, 0,  1, 0, 6'h00, 0, 3, 0, 0));
    vecs.push_back(mk(0, 1, 2, 0, 6'h02, 0, 0,  0, 1, 6'h01, 0, 3, 0, 0));
    vecs.push_back(mk(0, 1, 2, 0, 6'h02, 0, 0,  0, 0, 6'h00, 0, 3, 0, 0));
    vecs.push_back(mk(0, 1, 2, 0, 6'h02, 1, 0,  0, 0, 6'h00, 0, 3, 0, 0));
    vecs.push_back(mk(0, 1, 2, 0, 6'h02, 0, 0,  1, 0, 6'h00, 0, 3, 0, 0));
    vecs.push_back(mk(0, 1, 2, 0, 6'h13, 0, 0,  1, 1, 6'h02, 0, 3, 0, 0));
    vecs.push_back(mk(0, 1, 2, 1, 6'h00, 0, 0,  0, 1, 6'h13, 1, 3, 0, 0));
    vecs.push_back(mk(0, 1, 2, 1, 6'h00, 1, 0,  0, 0, 6'h00, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, 2, 1, 6'h00, 0, 1,  0, 0, 6'h00, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, 2, 1, 6'h00, 0, 0,  0, 0, 6'h00, 0, 2, 1, 0));
    vecs.push_back(mk(0, 1, 2, 1, 6'h00, 1, 0,  0, 0, 6'h00, 0, 2, 1, 0));
    vecs.push_back(mk(0, 1, 2, 0, 6'h01, 1, 0,  0, 0, 6'h00, 0, 4, 0, 1));
    vecs.push_back(mk(0, 1, 2, 0, 6'h01, 0, 1,  0, 0, 6'h00, 0, 4, 0, 1));

    // Reset state, with a non-empty source to prove pops are forced off.
    repeat (2) @(posedge clk);
    #1;
    fifo_empty = 1'b0; fifo_data = 6'h05;
    #1;
    check("rst state", state, 3'd0);
    check("rst pop", fifo_pop, 1'b0);
    check("rst valid", valid_out, 1'b0);
    check("rst data", data_out, 6'h00);
    check("rst sel", selector_out, 1'b0);
    check("rst idle", idle_out, 1'b0);
    check("rst err", error_out, 1'b0);
    step();

    foreach (vecs[i]) begin
      reset_L = 1'b1;
      init = vecs[i].init; umbral_0 = vecs[i].u0; umbral_1 = vecs[i].u1;
      fifo_empty = vecs[i].empty; fifo_data = vecs[i].data;
      free_0 = vecs[i].f0; free_1 = vecs[i].f1;
      #3;
      check($sformatf("v%0d pop", i), fifo_pop, vecs[i].e_pop);
      check($sformatf("v%0d valid", i), valid_out, vecs[i].e_valid);
      check($sformatf("v%0d data", i), data_out, vecs[i].e_data);
      check($sformatf("v%0d sel", i), selector_out, vecs[i].e_sel);
      check($sformatf("v%0d state", i), state, vecs[i].e_state);
      check($sformatf("v%0d idle", i), idle_out, vecs[i].e_idle);
      check($sformatf("v%0d err", i), error_out, vecs[i].e_err);
      @(posedge clk);
      #1;
    end
`ifdef DEMUX_CTRL_STATS_EN
    check("tbl cnt_0", cnt_0, 8'd2);
    check("tbl cnt_1", cnt_1, 8'd1);
`endif

    // ERROR is sticky against init and frees; only reset leaves it.
    init = 1'b1; free_0 = 1'b1; free_1 = 1'b0;
    step();
    step();
    check("err sticky state", state, 3'd4);
    check("err sticky flag", error_out, 1'b1);
    check("err no pop", fifo_pop, 1'b0);
    #2;
    reset_L = 1'b0;
    #1;
    check("err reset state", state, 3'd0);
    check("err reset flag", error_out, 1'b0);

    // Reset in the middle of a transfer drops the in-flight word at once.
    step();
    reset_L = 1'b1; init = 1'b1; umbral_0 = 3'd2; umbral_1 = 3'd2;
    free_0 = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
    step();
    check("mid init state", state, 3'd1);
    init = 1'b0;
    step();
    check("mid idle state", state, 3'd2);
    fifo_empty = 1'b0; fifo_data = 6'h15;
    step();
    check("mid active state", state, 3'd3);
    check("mid pop", fifo_pop, 1'b1);
    step();
    check("mid valid", valid_out, 1'b1);
    check("mid data", data_out, 6'h15);
    check("mid sel", selector_out, 1'b1);
    #2;
    reset_L = 1'b0;
    #1;
    check("mid drop valid", valid_out, 1'b0);
    check("mid drop data", data_out, 6'h00);
    check("mid drop state", state, 3'd0);
`ifdef DEMUX_CTRL_STATS_EN
    check("mid cnt_1 clr", cnt_1, 8'd0);
`endif

    // Randomized run against the behavioural model; frees only for words actually held.
    fifo_empty = 1'b1; fifo_data = '0; init = 1'b0; free_0 = 1'b0; free_1 = 1'b0;
    step();
    reset_L = 1'b1;
    m_mode = 0; m_cred = '{0, 0}; m_thr = '{0, 0}; m_cnt = '{0, 0};
    m_valid = 1'b0; m_data = '0; m_sel = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic       f[2];
      logic       bad;
      logic       base;
      logic       exp_pop;
      logic       dut_pop;
      logic [2:0] u[2];
      int         d;
      int         nxt;

      init = (cyc < 3) || ($urandom_range(0, 199) == 0);
      u[0] = 3'($urandom_range(0, 7));
      u[1] = 3'($urandom_range(0, 7));
      umbral_0 = u[0]; umbral_1 = u[1];
      if (src_q.size() < 6 && $urandom_range(0, 2) != 0) src_q.push_back(6'($urandom));
      fifo_empty = (src_q.size() == 0);
      fifo_data  = fifo_empty ? 6'($urandom) : src_q[0];
      for (int k = 0; k < 2; k++)
        f[k] = (m_mode == 2 || m_mode == 3) && (m_cred[k] < m_thr[k]) && ($urandom_range(0, 2) == 0);
      free_0 = f[0]; free_1 = f[1];
      #3;

      d    = int'(fifo_data[4]);
      base = (m_mode == 3) && !fifo_empty && (m_cred[d] > 0);
      bad  = 1'b0;
      for (int k = 0; k < 2; k++)
        if (f[k] && (m_mode == 2 || m_mode == 3) && m_cred[k] == m_thr[k] && !(base && d == k))
          bad = 1'b1;
      exp_pop = base && !bad;

      check($sformatf("r%0d pop", cyc), fifo_pop, exp_pop);
      check($sformatf("r%0d valid", cyc), valid_out, m_valid);
      check($sformatf("r%0d data", cyc), data_out, m_data);
      check($sformatf("r%0d sel", cyc), selector_out, m_sel);
      check($sformatf("r%0d state", cyc), state, 3'(m_mode));
      check($sformatf("r%0d idle", cyc), idle_out,
            (m_mode == 2) && (m_cred[0] == m_thr[0]) && (m_cred[1] == m_thr[1]));
      check($sformatf("r%0d err", cyc), error_out, m_mode == 4);
`ifdef DEMUX_CTRL_STATS_EN
      check($sformatf("r%0d cnt_0", cyc), cnt_0, 8'(m_cnt[0]));
      check($sformatf("r%0d cnt_1", cyc), cnt_1, 8'(m_cnt[1]));
`endif
      dut_pop = fifo_pop;

      @(posedge clk);
      if (dut_pop && src_q.size() > 0) void'(src_q.pop_front());
      m_valid = exp_pop;
      m_data  = exp_pop ? fifo_data : 6'h00;
      m_sel   = exp_pop && (d == 1);
      if (m_mode == 0 || m_mode == 1) begin
        m_cnt = '{0, 0};
        if (m_mode == 1) begin
          m_thr[0] = int'(u[0]); m_thr[1] = int'(u[1]);
          m_cred = m_thr;
        end
      end else begin
        if (exp_pop && m_cnt[d] < 255) m_cnt[d]++;
        if ((m_mode == 2 || m_mode == 3) && !bad)
          for (int k = 0; k < 2; k++)
            m_cred[k] += (f[k] ? 1 : 0) - ((exp_pop && d == k) ? 1 : 0);
      end
      case (m_mode)
        0: nxt = 1;
        1: nxt = init ? 1 : 2;
        2: nxt = bad ? 4 : init ? 1 : !fifo_empty ? 3 : 2;
        3: nxt = bad ? 4 : init ? 1 : fifo_empty ? 2 : 3;
        default: nxt = 4;
      endcase
      m_mode = nxt;
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
